// File: rtl/wb_regfile.sv
// wb_regfile: writeback stage of the pipeline.
// Contains the result-select mux, the integer register file (x0..x31) and
// the retired-instruction counter. The decode read ports bypass a same-cycle
// W-stage write, so the decode stage never has to stall on a W->D dependency.
module wb_regfile #(
  parameter int XLEN  = 32,
  parameter int AW    = 5,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,        // asynchronous, active-low
  input  logic [XLEN-1:0]  ALUResultW,
  input  logic [XLEN-1:0]  ReadDataW,
  input  logic [XLEN-1:0]  PCPlus4W,
  input  logic [AW-1:0]    RdW,
  input  logic             RegWriteW,
  input  logic [1:0]       ResultSrcW,
  input  logic [31:0]      InstruW,
  input  logic [AW-1:0]    Rs1D,
  input  logic [AW-1:0]    Rs2D,
  output logic [XLEN-1:0]  RD1D,
  output logic [XLEN-1:0]  RD2D,
  output logic [XLEN-1:0]  ResultW,
  output logic [CNT_W-1:0] RetiredW
);

  localparam int NREG = 2 ** AW;

  logic [XLEN-1:0]  regs_q [NREG];
  logic [XLEN-1:0]  regs_d [NREG];
  logic [CNT_W-1:0] retired_q;
  logic [CNT_W-1:0] retired_d;

  // Qualified write strobe: x0 writes are dropped here, so entry 0 never changes.
  logic wr_en;
  assign wr_en = RegWriteW && (RdW != '0);

  // Result select: ALU / load data / link address / zero.
  always_comb begin
    ResultW = '0;
    case (ResultSrcW)
      2'b00:   ResultW = ALUResultW;
      2'b01:   ResultW = ReadDataW;
      2'b10:   ResultW = PCPlus4W;
      default: ResultW = '0;
    endcase
  end

  // Next register-file contents: one entry updated per cycle at most.
  always_comb begin
    regs_d = regs_q;
    if (wr_en) begin
      regs_d[RdW] = ResultW;
    end
  end

  // Next counter value: every non-bubble instruction retires, store/branch included.
  always_comb begin
    retired_d = retired_q;
    if (InstruW != 32'h0) begin
      retired_d = retired_q + 1'b1;
    end
  end

  // State registers; while reset is low every write and count is held off.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
      retired_q <= '0;
    end else begin
      regs_q    <= regs_d;
      retired_q <= retired_d;
    end
  end

  // Read port 1: x0 is zero, then the W-stage bypass (only out of reset), then storage.
  always_comb begin
    RD1D = '0;
    if (Rs1D == '0) begin
      RD1D = '0;
    end else if (reset && RegWriteW && (RdW == Rs1D)) begin
      RD1D = ResultW;
    end else begin
      RD1D = regs_q[Rs1D];
    end
  end

  // Read port 2: same rules as port 1, fully independent of it.
  always_comb begin
    RD2D = '0;
    if (Rs2D == '0) begin
      RD2D = '0;
    end else if (reset && RegWriteW && (RdW == Rs2D)) begin
      RD2D = ResultW;
    end else begin
      RD2D = regs_q[Rs2D];
    end
  end

  assign RetiredW = retired_q;

endmodule

// File: tb/tb_wb_regfile.sv
// tb_wb_regfile: table-driven directed vectors, hand-written reset/counter
// sequences and a randomized run against a behavioural model of the register file.
module tb_wb_regfile;

  localparam int XLEN = 32;
  localparam int AW   = 5;

  // ---------------- clock / reset ----------------
  logic clk;
  logic reset;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic [XLEN-1:0] alu_w, rdata_w, pc4_w;
  logic [AW-1:0]   rd_w, rs1_d, rs2_d;
  logic            we_w;
  logic [1:0]      src_w;
  logic [31:0]     instr_w;
  logic [XLEN-1:0] rd1_d, rd2_d, result_w;
  logic [31:0]     retired_w;
  logic [XLEN-1:0] s_rd1_d, s_rd2_d, s_result_w;
  logic [3:0]      s_retired_w;

  wb_regfile #(.XLEN(32), .AW(5), .CNT_W(32)) dut (
    .clk(clk), .reset(reset),
    .ALUResultW(alu_w), .ReadDataW(rdata_w), .PCPlus4W(pc4_w),
    .RdW(rd_w), .RegWriteW(we_w), .ResultSrcW(src_w), .InstruW(instr_w),
    .Rs1D(rs1_d), .Rs2D(rs2_d),
    .RD1D(rd1_d), .RD2D(rd2_d), .ResultW(result_w), .RetiredW(retired_w)
  );

  // Narrow-counter build, sharing all inputs, to reach the wrap point quickly.
  wb_regfile #(.XLEN(32), .AW(5), .CNT_W(4)) dut_small (
    .clk(clk), .reset(reset),
    .ALUResultW(alu_w), .ReadDataW(rdata_w), .PCPlus4W(pc4_w),
    .RdW(rd_w), .RegWriteW(we_w), .ResultSrcW(src_w), .InstruW(instr_w),
    .Rs1D(rs1_d), .Rs2D(rs2_d),
    .RD1D(s_rd1_d), .RD2D(s_rd2_d), .ResultW(s_result_w), .RetiredW(s_retired_w)
  );

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [XLEN-1:0] ref_regs [32];
  int unsigned     ref_retired;

  function automatic logic [XLEN-1:0] ref_result();
    logic [XLEN-1:0] r;
    if (src_w == 2'd0)      r = alu_w;
    else if (src_w == 2'd1) r = rdata_w;
    else if (src_w == 2'd2) r = pc4_w;
    else                    r = '0;
    return r;
  endfunction

  function automatic logic [XLEN-1:0] ref_read(input logic [AW-1:0] a);
    if (a == 0) return '0;
    if (reset && we_w && rd_w == a) return ref_result();
    return ref_regs[a];
  endfunction

  // Commit the current inputs into the model (call for each active edge).
  task automatic model_edge();
    if (reset) begin
      if (we_w && rd_w != 0) ref_regs[rd_w] = ref_result();
      if (instr_w != 32'h0) ref_retired++;
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) ref_regs[i] = '0;
    ref_retired = 0;
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    alu_w = '0; rdata_w = '0; pc4_w = '0; rd_w = '0; we_w = 1'b0;
    src_w = 2'd0; instr_w = 32'h0; rs1_d = '0; rs2_d = '0;
  endtask

  // One clock edge; inputs are held across it and outputs settle 1 ns later.
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [AW-1:0]   rd;
    logic            we;
    logic [1:0]      src;
    logic [XLEN-1:0] alu;
    logic [XLEN-1:0] rdata;
    logic [XLEN-1:0] pc4;
    logic [AW-1:0]   rs1;
    logic [AW-1:0]   rs2;
    logic [XLEN-1:0] exp_rd1;
    logic [XLEN-1:0] exp_rd2;
    logic [XLEN-1:0] exp_res;
  } vec_t;

  vec_t vecs [9];

  initial begin
    // Applied in order from an all-zero register file; each row is followed by one edge.
    vecs[0] = '{5'd5, 1'b1, 2'd0, 32'hDEADBEEF, 32'h0, 32'h0, 5'd5, 5'd0, 32'hDEADBEEF, 32'h0, 32'hDEADBEEF};
    vecs[1] = '{5'd0, 1'b0, 2'd0, 32'h0, 32'h0, 32'h0, 5'd5, 5'd5, 32'hDEADBEEF, 32'hDEADBEEF, 32'h0};
    vecs[2] = '{5'd7, 1'b1, 2'd1, 32'h0, 32'h12345678, 32'h0, 5'd7, 5'd7, 32'h12345678, 32'h12345678, 32'h12345678};
    vecs[3] = '{5'd0, 1'b0, 2'd1, 32'h0, 32'h0, 32'h0, 5'd7, 5'd5, 32'h12345678, 32'hDEADBEEF, 32'h0};
    vecs[4] = '{5'd0, 1'b1, 2'd0, 32'hFFFFFFFF, 32'h0, 32'h0, 5'd0, 5'd0, 32'h0, 32'h0, 32'hFFFFFFFF};
    vecs[5] = '{5'd0, 1'b0, 2'd2, 32'h0, 32'h0, 32'h00000104, 5'd0, 5'd7, 32'h0, 32'h12345678, 32'h00000104};
    vecs[6] = '{5'd0, 1'b0, 2'd3, 32'hAAAA5555, 32'h5555AAAA, 32'h00000104, 5'd5, 5'd0, 32'hDEADBEEF, 32'h0, 32'h0};
    vecs[7] = '{5'd5, 1'b1, 2'd2, 32'h0, 32'h0, 32'h0000AAAA, 5'd5, 5'd5, 32'h0000AAAA, 32'h0000AAAA, 32'h0000AAAA};
    vecs[8] = '{5'd0, 1'b0, 2'd0, 32'h0, 32'h0, 32'h0, 5'd5, 5'd7, 32'h0000AAAA, 32'h12345678, 32'h0};
  end

  // ---------------- main sequence ----------------
  initial begin
    idle_inputs();
    model_reset();
    reset = 1'b0;
    @(posedge clk);
    #1;
    // Reset state: every address reads zero on both ports, counter zero.
    for (int i = 0; i < 32; i++) begin
      rs1_d = 5'(i);
      rs2_d = 5'(31 - i);
      #1;
      check($sformatf("reset_rd1_x%0d", i), rd1_d, 32'h0);
      check($sformatf("reset_rd2_x%0d", 31 - i), rd2_d, 32'h0);
    end
    check("reset_retired", retired_w, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    #1;

    // Directed table.
    for (int v = 0; v < 9; v++) begin
      rd_w = vecs[v].rd; we_w = vecs[v].we; src_w = vecs[v].src;
      alu_w = vecs[v].alu; rdata_w = vecs[v].rdata; pc4_w = vecs[v].pc4;
      rs1_d = vecs[v].rs1; rs2_d = vecs[v].rs2;
      #1;
      check($sformatf("vec%0d_rd1", v), rd1_d, vecs[v].exp_rd1);
      check($sformatf("vec%0d_rd2", v), rd2_d, vecs[v].exp_rd2);
      check($sformatf("vec%0d_result", v), result_w, vecs[v].exp_res);
      tick();
    end
    // x0 write attempt must not have landed.
    idle_inputs();
    #1;
    check("x0_after_write", rd1_d, 32'h0);

    // Reset asserted mid-operation: no bypass, storage cleared, coincident write lost.
    rd_w = 5'd9; we_w = 1'b1; src_w = 2'd0; alu_w = 32'hCAFEF00D;
    rs1_d = 5'd9; rs2_d = 5'd5;
    #1;
    check("pre_reset_bypass", rd1_d, 32'hCAFEF00D);
    reset = 1'b0;
    #1;
    model_reset();
    check("reset_no_bypass", rd1_d, 32'h0);
    check("reset_async_clear", rd2_d, 32'h0);
    tick();
    instr_w = 32'h00500093;
    tick();
    check("reset_write_lost", rd1_d, 32'h0);
    check("reset_no_count", retired_w, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    idle_inputs();
    rs1_d = 5'd9;
    #1;
    check("post_reset_x9", rd1_d, 32'h0);

    // Retire counter: 10 cycles alternating instruction / bubble -> 5.
    for (int c = 0; c < 10; c++) begin
      instr_w = (c % 2 == 0) ? 32'h00500093 : 32'h0;
      we_w = (c % 4 == 0);
      rd_w = 5'd3;
      tick();
    end
    check("retired_after_10", retired_w, 32'd5);
    check("small_retired_after_10", {28'h0, s_retired_w}, 32'd5);
    // Bring the 4-bit counter to 15, then one more instruction wraps it to 0.
    instr_w = 32'h00000013;
    we_w = 1'b0;
    for (int c = 0; c < 10; c++) tick();
    check("small_retired_max", {28'h0, s_retired_w}, 32'd15);
    tick();
    check("small_retired_wrap", {28'h0, s_retired_w}, 32'd0);
    check("retired_16", retired_w, 32'd16);

    // Randomized run against the model.
    for (int n = 0; n < 400; n++) begin
      rd_w    = 5'($urandom_range(0, 31));
      we_w    = 1'($urandom_range(0, 1));
      src_w   = 2'($urandom_range(0, 3));
      alu_w   = $urandom;
      rdata_w = $urandom;
      pc4_w   = $urandom;
      instr_w = ($urandom_range(0, 1) == 1) ? $urandom : 32'h0;
      rs1_d   = ($urandom_range(0, 3) == 0) ? rd_w : 5'($urandom_range(0, 31));
      rs2_d   = ($urandom_range(0, 3) == 0) ? rd_w : 5'($urandom_range(0, 31));
      #1;
      check("rand_result", result_w, ref_result());
      check("rand_rd1", rd1_d, ref_read(rs1_d));
      check("rand_rd2", rd2_d, ref_read(rs2_d));
      tick();
      check("rand_retired", retired_w, ref_retired);
      check("rand_small_retired", {28'h0, s_retired_w}, ref_retired % 16);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
